// File: rtl/ico_uart_pkg.sv
// rtl/ico_uart_pkg.sv - shared UART types and constants for the icoboard RX/TX blocks
package ico_uart_pkg;
    localparam int UART_DATA_BITS = 8;
    // 47.9 MHz core clock at 115200 baud
    localparam int UART_DEFAULT_CLKS_PER_BIT = 416;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;
endpackage

// File: rtl/ico_sync_fifo.sv
// rtl/ico_sync_fifo.sv - single-clock circular FIFO with registered head word
module ico_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
    logic                  do_push;
    logic                  do_pop;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
            // Head register bypasses the write when the new head is the word being pushed
            if (do_push || do_pop) begin
                rdata <= (do_push && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
            end
        end
    end
endmodule

// File: rtl/ico_uart_rx.sv
// rtl/ico_uart_rx.sv - 8N1 UART receiver with RX FIFO; ICO_UART_RX_CTS_EN builds the cts_n level detect
module ico_uart_rx
    import ico_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       rx,
    output logic       cts_n,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clear
);
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rxs;
    uart_state_t               state;
    logic [15:0]               bit_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      stop_sample;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [DEPTH_LOG2:0]       count;

    always_ff @(posedge clk_core) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: if (!rxs) begin
                    bit_cnt <= HALF_LOAD;
                    state   <= START;
                end
                START: if (bit_cnt != 16'd0) begin
                    bit_cnt <= bit_cnt - 16'd1;
                end else if (rxs) begin
                    state <= IDLE;
                end else begin
                    state   <= DATA;
                    bit_idx <= '0;
                    bit_cnt <= FULL_LOAD;
                end
                DATA: if (bit_cnt != 16'd0) begin
                    bit_cnt <= bit_cnt - 16'd1;
                end else begin
                    shift   <= {rxs, shift[UART_DATA_BITS-1:1]};
                    bit_cnt <= FULL_LOAD;
                    if (bit_idx == LAST_BIT) begin
                        state <= STOP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: if (bit_cnt != 16'd0) begin
                    bit_cnt <= bit_cnt - 16'd1;
                end else begin
                    state <= rxs ? IDLE : BREAK;
                end
                BREAK: if (rxs) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push is taken straight off the sample edge so the byte is visible one cycle later
    assign stop_sample = (state == STOP) && (bit_cnt == 16'd0);
    assign push        = stop_sample && rxs;
    assign pop         = rd_valid && rd_ready;
    assign rd_valid    = !empty;

    ico_sync_fifo #(
        .WIDTH      (UART_DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_core),
        .reset (reset),
        .push  (push),
        .wdata (shift),
        .pop   (pop),
        .rdata (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_core) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !err_clear) || (stop_sample && !rxs);
            overrun   <= (overrun && !err_clear) || (push && full && !pop);
        end
    end

`ifdef ICO_UART_RX_CTS_EN
    localparam logic [DEPTH_LOG2:0] CTS_LEVEL = (DEPTH_LOG2 + 1)'((1 << DEPTH_LOG2) - 1);
    logic                push_ok;
    logic [DEPTH_LOG2:0] count_next;

    assign push_ok    = push && (!full || pop);
    assign count_next = count + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop};

    always_ff @(posedge clk_core) begin
        if (reset) begin
            cts_n <= 1'b0;
        end else begin
            cts_n <= (count_next >= CTS_LEVEL);
        end
    end
`else
    logic unused_count;
    assign unused_count = ^count;
    assign cts_n        = 1'b0;
`endif
endmodule

// File: tb/tb_ico_uart_rx.sv
// tb/tb_ico_uart_rx.sv - randomized bench for ico_uart_rx against a byte-queue reference model
module tb_ico_uart_rx;
    localparam int CPB   = 16;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_ready;
    logic       err_clear;
    logic       cts_n;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk_core = ~clk_core;

    ico_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL)
    ) dut (
        .clk_core  (clk_core),
        .reset     (reset),
        .rx        (rx),
        .cts_n     (cts_n),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clear (err_clear)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_cts();
`ifdef ICO_UART_RX_CTS_EN
        return (q.size() >= DEPTH - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".valid"}, rd_valid, (q.size() != 0));
        if (q.size() != 0) check({tag, ".data"}, rd_data, q[0]);
        check({tag, ".frame_err"}, frame_err, m_fe);
        check({tag, ".overrun"}, overrun, m_ov);
        check({tag, ".cts_n"}, cts_n, exp_cts());
    endtask

    // mode: 0 plain, 1 latency probe, 2 pop on the stop-sample edge, 3 reset at data bit 3
    task automatic send_frame(input logic [7:0] d, input logic stop, input int mode, input int tail_low);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < CPB; i++) begin
                @(negedge clk_core);
                rx = bits[j];
                if (mode == 3 && j == 4 && i == 0) begin
                    rx    = 1'b1;
                    reset = 1'b1;
                    repeat (2) @(negedge clk_core);
                    reset = 1'b0;
                    q.delete();
                    m_fe = 1'b0;
                    m_ov = 1'b0;
                    return;
                end
                if (j == 9 && i == 10) begin
                    if (mode == 1) check("lat.before", rd_valid, 1'b0);
                    if (mode == 2) rd_ready = 1'b1;
                end
                if (j == 9 && i == 11) begin
                    if (mode == 1) check("lat.after", rd_valid, 1'b1);
                    if (mode == 2) rd_ready = 1'b0;
                end
            end
        end
        for (int k = 0; k < tail_low; k++) begin
            @(negedge clk_core);
            rx = 1'b0;
        end
        @(negedge clk_core);
        rx = 1'b1;
        repeat (4) @(negedge clk_core);
        if (!stop) begin
            m_fe = 1'b1;
        end else begin
            if (mode == 2 && q.size() != 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(d);
            else m_ov = 1'b1;
        end
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk_core);
        check({tag, ".pop_valid"}, rd_valid, 1'b1);
        if (q.size() != 0) check({tag, ".pop_data"}, rd_data, q[0]);
        rd_ready = 1'b1;
        @(negedge clk_core);
        rd_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_errors();
        @(negedge clk_core);
        err_clear = 1'b1;
        @(negedge clk_core);
        err_clear = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    initial begin
        int n;
        rx        = 1'b1;
        rd_ready  = 1'b0;
        err_clear = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk_core);
        reset = 1'b0;
        @(negedge clk_core);
        check_status("reset");
        check("reset.rd_data", rd_data, 8'h00);

        send_frame(8'hA5, 1'b1, 1, 0);
        check_status("a5");
        pop_one("a5");
        @(negedge clk_core);
        check_status("a5.drained");

        send_frame(8'h00, 1'b0, 0, 40);
        check_status("break");
        clear_errors();
        check_status("break.clr");

        @(negedge clk_core);
        rx = 1'b0;
        repeat (5) @(negedge clk_core);
        rx = 1'b1;
        repeat (40) @(negedge clk_core);
        check_status("glitch");

        send_frame(8'h11, 1'b1, 0, 0);
        check_status("fill1");
        send_frame(8'h22, 1'b1, 0, 0);
        check_status("fill2");
        send_frame(8'h33, 1'b1, 0, 0);
        check_status("fill3");
        send_frame(8'h44, 1'b1, 0, 0);
        check_status("fill4");
        send_frame(8'h55, 1'b1, 0, 0);
        check_status("ovr");
        repeat (4) pop_one("ovr");
        @(negedge clk_core);
        check_status("ovr.drained");
        clear_errors();
        check_status("ovr.clr");

        for (int k = 0; k < DEPTH; k++) send_frame(8'($urandom), 1'b1, 0, 0);
        check_status("full");
        send_frame(8'h66, 1'b1, 2, 0);
        check_status("same_cycle");
        repeat (DEPTH - 1) pop_one("same");
        check("same.last", rd_data, 8'h66);
        pop_one("same");
        @(negedge clk_core);
        check_status("same.drained");

        send_frame(8'h5A, 1'b1, 3, 0);
        @(negedge clk_core);
        check_status("abort");
        send_frame(8'h3C, 1'b1, 0, 0);
        check_status("after_abort");
        pop_one("after_abort");

        for (int it = 0; it < 20; it++) begin
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 0, 0);
            check_status("rand");
            n = $urandom_range(0, q.size());
            for (int p = 0; p < n; p++) pop_one("rand");
            if ($urandom_range(0, 3) == 0) clear_errors();
            @(negedge clk_core);
            check_status("rand.post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
